// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame FSM encoding and baud divisor helper.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level output; a push into a full FIFO is dropped even if a pop
// happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        empty   = (level_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        rdata   = mem[rd_ptr_q];
        level   = level_q;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) level_q <= level_q + 1'b1;
            else if (!do_push && do_pop) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO; queued frames go out back-to-back with no idle gap.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 60000000,
    parameter int unsigned BAUD_RATE   = 6000000,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 1,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_BITS-1:0]               data_to_tx,
    input  logic                               wr_en,
    output logic                               tx_ready,
    output logic                               tx,
    output logic                               tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W        = $clog2(DATA_BITS);

    if (CLKS_PER_BIT < 2) begin : gen_bad_baud
        $error("uart_tx_fifo: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_width
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE > PARITY_ODD) begin : gen_bad_parity
        $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BIT_W-1:0]       bit_q;
    logic                   stop_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   par_q;
    logic                   tx_q;

    logic                   fifo_full, fifo_empty, pop;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   baud_done, last_stop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop),
        .wdata (data_to_tx),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        baud_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        last_stop = (STOP_BITS == 2) ? stop_q : 1'b1;
        // Pop either from idle or exactly at the end of the final stop bit.
        pop       = !fifo_empty &&
                    ((state_q == StIdle) || (state_q == StStop && baud_done && last_stop));
        tx_ready  = !fifo_full;
        tx_busy   = (state_q != StIdle) || (fifo_level != '0);
        tx        = tx_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            cnt_q <= (state_q == StIdle || baud_done) ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        shreg_q <= fifo_rdata;
                        par_q   <= (^fifo_rdata) ^ (PARITY_MODE == PARITY_ODD);
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_done) begin
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        bit_q   <= '0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (baud_done) begin
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                            stop_q <= 1'b0;
                            if (PARITY_MODE != PARITY_NONE) begin
                                tx_q    <= par_q;
                                state_q <= StParity;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            tx_q    <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                            bit_q   <= bit_q + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (baud_done) begin
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b0;
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (baud_done) begin
                        if (!last_stop) begin
                            stop_q <= 1'b1;
                        end else if (pop) begin
                            shreg_q <= fifo_rdata;
                            par_q   <= (^fifo_rdata) ^ (PARITY_MODE == PARITY_ODD);
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations, frames checked bit-by-bit against a queue.
module tb_uart_tx_fifo;

    localparam int C = 10;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] wr = 3'b000;
    logic [7:0] d0 = '0;
    logic [6:0] d1 = '0;
    logic [4:0] d2 = '0;
    logic [2:0] tx_w, busy_w, rdy_w;
    logic [2:0] lvl0, lvl1, lvl2;

    frame_t exp_q [3][$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc;

    always #5 clk = ~clk;

    uart_tx_fifo u_dut0 (
        .clk (clk), .reset (reset), .data_to_tx (d0), .wr_en (wr[0]),
        .tx_ready (rdy_w[0]), .tx (tx_w[0]), .tx_busy (busy_w[0]), .fifo_level (lvl0)
    );

    uart_tx_fifo #(
        .DATA_BITS (7), .PARITY_MODE (2), .STOP_BITS (2)
    ) u_dut1 (
        .clk (clk), .reset (reset), .data_to_tx (d1), .wr_en (wr[1]),
        .tx_ready (rdy_w[1]), .tx (tx_w[1]), .tx_busy (busy_w[1]), .fifo_level (lvl1)
    );

    uart_tx_fifo #(
        .DATA_BITS (5), .PARITY_MODE (0), .STOP_BITS (1)
    ) u_dut2 (
        .clk (clk), .reset (reset), .data_to_tx (d2), .wr_en (wr[2]),
        .tx_ready (rdy_w[2]), .tx (tx_w[2]), .tx_busy (busy_w[2]), .fifo_level (lvl2)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic frame_t build_frame(input int idx, input logic [8:0] d);
        frame_t f;
        int     dbits, pmode, sbits;
        logic   par;
        dbits = (idx == 0) ? 8 : (idx == 1) ? 7 : 5;
        pmode = (idx == 0) ? 1 : (idx == 1) ? 2 : 0;
        sbits = (idx == 1) ? 2 : 1;
        f.bits = '0;
        f.n    = 1;
        par    = 1'b0;
        for (int i = 0; i < dbits; i++) begin
            f.bits[f.n] = d[i];
            par = par ^ d[i];
            f.n++;
        end
        if (pmode != 0) begin
            f.bits[f.n] = (pmode == 2) ? ~par : par;
            f.n++;
        end
        for (int i = 0; i < sbits; i++) begin
            f.bits[f.n] = 1'b1;
            f.n++;
        end
        return f;
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic write_word(input int idx, input logic [8:0] d, input bit accept);
        case (idx)
            0: d0 = d[7:0];
            1: d1 = d[6:0];
            default: d2 = d[4:0];
        endcase
        wr[idx] = 1'b1;
        @(posedge clk);
        if (accept) exp_q[idx].push_back(build_frame(idx, d));
        @(negedge clk);
        wr[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx, input int limit, output int n);
        n = 0;
        while (busy_w[idx] && n < limit) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic monitor(input int idx);
        frame_t f;
        int     good;
        bit     abort;
        forever begin
            @(negedge clk);
            if (!reset && tx_w[idx] == 1'b0) begin
                if (exp_q[idx].size() == 0) begin
                    check_eq($sformatf("dut%0d_unexpected_frame", idx), 1, 0);
                    for (int k = 0; k < 2000 && busy_w[idx]; k++) @(negedge clk);
                end else begin
                    f = exp_q[idx].pop_front();
                    abort = 1'b0;
                    for (int b = 0; b < f.n && !abort; b++) begin
                        good = 0;
                        for (int c = 0; c < C && !abort; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (reset) abort = 1'b1;
                            else if (tx_w[idx] == f.bits[b]) good++;
                        end
                        if (!abort) check_eq($sformatf("dut%0d_bit%0d_cycles", idx, b), good, C);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_tx", int'(tx_w[0]), 1);
        check_eq("rst_busy", int'(busy_w[0]), 0);
        check_eq("rst_ready", int'(rdy_w[0]), 1);
        check_eq("rst_level", int'(lvl0), 0);
        check_eq("rst_busy_all", int'(busy_w), 0);
        reset = 1'b0;
        @(negedge clk);

        // 8E1 single frame
        write_word(0, 9'h0A5, 1'b1);
        check_eq("a5_level", int'(lvl0), 1);
        wait_idle(0, 300, cyc);
        check_eq("a5_busy_fall", cyc, 111);

        // 7O2 single frame
        write_word(1, 9'h07F, 1'b1);
        wait_idle(1, 300, cyc);
        check_eq("7f_busy_fall", cyc, 111);

        // 5N1 single frame
        write_word(2, 9'h015, 1'b1);
        wait_idle(2, 300, cyc);
        check_eq("15_busy_fall", cyc, 71);

        // Four back-to-back writes
        write_word(0, 9'h001, 1'b1);
        check_eq("b2b_lvl1", int'(lvl0), 1);
        write_word(0, 9'h002, 1'b1);
        check_eq("b2b_lvl2", int'(lvl0), 1);
        write_word(0, 9'h003, 1'b1);
        check_eq("b2b_lvl3", int'(lvl0), 2);
        write_word(0, 9'h004, 1'b1);
        check_eq("b2b_lvl4", int'(lvl0), 3);
        check_eq("b2b_ready", int'(rdy_w[0]), 1);
        wait_idle(0, 1000, cyc);
        check_eq("b2b_busy_fall", cyc, 438);

        // Overflow while a frame is in flight
        write_word(0, 9'h011, 1'b1);
        write_word(0, 9'h022, 1'b1);
        write_word(0, 9'h033, 1'b1);
        write_word(0, 9'h044, 1'b1);
        write_word(0, 9'h055, 1'b1);
        check_eq("ovf_level_full", int'(lvl0), 4);
        check_eq("ovf_ready_low", int'(rdy_w[0]), 0);
        write_word(0, 9'h0EE, 1'b0);
        check_eq("ovf_level_kept", int'(lvl0), 4);
        check_eq("ovf_ready_still_low", int'(rdy_w[0]), 0);
        wait_idle(0, 1000, cyc);
        check_eq("ovf_drained", int'(busy_w[0]), 0);

        // Reset in the DATA state of the second queued frame
        write_word(0, 9'h081, 1'b1);
        write_word(0, 9'h042, 1'b1);
        write_word(0, 9'h099, 1'b1);
        repeat (150) @(negedge clk);
        check_eq("pre_rst_busy", int'(busy_w[0]), 1);
        #2;
        reset = 1'b1;
        exp_q[0].delete();
        #1;
        check_eq("mid_rst_tx", int'(tx_w[0]), 1);
        check_eq("mid_rst_level", int'(lvl0), 0);
        check_eq("mid_rst_busy", int'(busy_w[0]), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        write_word(0, 9'h03C, 1'b1);
        wait_idle(0, 300, cyc);
        check_eq("3c_busy_fall", cyc, 111);

        repeat (5) @(negedge clk);
        check_eq("q0_empty", exp_q[0].size(), 0);
        check_eq("q1_empty", exp_q[1].size(), 0);
        check_eq("q2_empty", exp_q[2].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
